stream2rgb: RTL and testbench

Inverse of the camera-side pixel packer. Consumes the 32-bit packed data stream (frame start, header, pixel and other dtype words) and unpacks it into one pixel per cycle: raw pixels on meta_datao, or r/g/b triplets. It also unpacks header words into 16-bit meta values, and recovers image_type from the header. It sits on the host/readback side, between the 32-bit transport and the pixel-domain Imager blocks.

---
 rtl/stream2rgb_pkg.sv | 36 +++
 rtl/stream2rgb_if.sv | 19 +
 rtl/stream2rgb_unpack.sv | 52 +++++
 rtl/stream2rgb.sv | 131 +++++++++++++
 tb/tb_stream2rgb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream2rgb_pkg.sv
// rtl/stream2rgb_pkg.sv - shared types, widths and mode helper for stream2rgb
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 16
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 16'hFF00
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 16'h0001
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 16'h0002
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 16'h0004
`endif
`ifndef Image_image_type
`define Image_image_type 2
`endif

package stream2rgb_pkg;

  typedef enum logic {RUN, HDR_HI} state_t;

  localparam int DATA_WIDTH = 32;
  localparam int META_WIDTH = 16;
  localparam int CNT_WIDTH  = 6;
  localparam int HIDX_WIDTH = 8;

  // Bits per output sample: one raw sample, or a packed r/g/b triplet.
  function automatic logic [CNT_WIDTH-1:0] pix_bits(input logic [META_WIDTH-1:0] image_type,
                                                    input int pw);
    return (image_type == '0) ? CNT_WIDTH'(pw) : CNT_WIDTH'(3 * pw);
  endfunction

endpackage

// File: rtl/stream2rgb_if.sv
// rtl/stream2rgb_if.sv - packed-word input and pixel output bundle for stream2rgb
interface stream2rgb_if #(parameter int PIXEL_WIDTH = 10);
  logic                    dvi;
  logic                    rdyo;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [31:0]             datai;
  logic                    dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]             meta_datao;
  logic [PIXEL_WIDTH-1:0]  r;
  logic [PIXEL_WIDTH-1:0]  g;
  logic [PIXEL_WIDTH-1:0]  b;
  logic [15:0]             image_typeo;

  modport master (output dvi, dtypei, datai,
                  input  rdyo, dvo, dtypeo, meta_datao, r, g, b, image_typeo);
  modport slave  (input  dvi, dtypei, datai,
                  output rdyo, dvo, dtypeo, meta_datao, r, g, b, image_typeo);
endinterface

// File: rtl/stream2rgb_unpack.sv
// rtl/stream2rgb_unpack.sv - LSB-first bit accumulator and sample extraction for stream2rgb
module stream2rgb_unpack
  import stream2rgb_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     en,
  input  logic [CNT_WIDTH-1:0]     p,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic [CNT_WIDTH-1:0]     cnt,
  output logic                     hit,
  output logic [3*PIXEL_WIDTH-1:0] sample
);
  localparam int PMAX  = 3 * PIXEL_WIDTH;
  localparam int ACC_W = DATA_WIDTH + PMAX - 1;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     comb;
  logic [CNT_WIDTH-1:0] cnt_n;

  // A word is only loaded while cnt < p, so comb never overflows ACC_W.
  always_comb begin
    comb  = acc;
    cnt_n = cnt;
    if (load) begin
      comb  = acc | (ACC_W'(data) << cnt);
      cnt_n = cnt + CNT_WIDTH'(DATA_WIDTH);
    end
    hit    = en && (cnt_n >= p);
    sample = comb[PMAX-1:0] & ~({PMAX{1'b1}} << p);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (hit) begin
      acc <= comb >> p;
      cnt <= cnt_n - p;
    end else if (load) begin
      acc <= comb;
      cnt <= cnt_n;
    end
  end
endmodule

// File: rtl/stream2rgb.sv
// rtl/stream2rgb.sv - unpacks the 32-bit transport stream into one raw or rgb pixel per cycle
module stream2rgb
  import stream2rgb_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 10,
  parameter int RAW_PIXEL_SHIFT = 0
) (
  input  logic        clk,
  input  logic        resetb,
  stream2rgb_if.slave s
);
  localparam int SW = (3 * PIXEL_WIDTH + RAW_PIXEL_SHIFT > META_WIDTH) ?
                      3 * PIXEL_WIDTH + RAW_PIXEL_SHIFT : META_WIDTH;

  state_t                   state;
  logic [CNT_WIDTH-1:0]     p;
  logic [CNT_WIDTH-1:0]     cnt;
  logic                     hit;
  logic [3*PIXEL_WIDTH-1:0] sample;
  logic                     accept, is_pix, is_start, is_hdr, is_other, hdr_emit;
  logic [META_WIDTH-1:0]    hdr_hi, hdr_val, raw_meta;
  logic [SW-1:0]            raw_wide;
  logic [`DTYPE_WIDTH-1:0]  pix_dtype;
  logic [HIDX_WIDTH-1:0]    hidx;

  logic                     dvo_q;
  logic [`DTYPE_WIDTH-1:0]  dtype_q;
  logic [META_WIDTH-1:0]    meta_q;
  logic [PIXEL_WIDTH-1:0]   r_q, g_q, b_q;
  logic [META_WIDTH-1:0]    itype_q;

  assign p        = pix_bits(itype_q, PIXEL_WIDTH);
  assign s.rdyo   = (state == RUN) && (cnt < p);
  assign accept   = s.dvi && s.rdyo;
  assign is_pix   = accept && ((s.dtypei & `DTYPE_PIXEL_MASK) != '0);
  assign is_start = accept && !is_pix && ((s.dtypei == `DTYPE_FRAME_START) ||
                                          (s.dtypei == `DTYPE_HEADER_START));
  assign is_hdr   = accept && !is_pix && (s.dtypei == `DTYPE_HEADER);
  assign is_other = accept && !is_pix && !is_start && !is_hdr;
  assign hdr_emit = is_hdr || (state == HDR_HI);
  assign hdr_val  = is_hdr ? s.datai[15:0] : hdr_hi;
  assign raw_wide = SW'(sample) << RAW_PIXEL_SHIFT;
  assign raw_meta = raw_wide[META_WIDTH-1:0];

  stream2rgb_unpack #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_unpack (
    .clk    (clk),
    .resetb (resetb),
    .clear  (is_start),
    .load   (is_pix),
    .en     (state == RUN),
    .p      (p),
    .data   (s.datai),
    .cnt    (cnt),
    .hit    (hit),
    .sample (sample)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= RUN;
      dvo_q     <= 1'b0;
      dtype_q   <= '0;
      meta_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      itype_q   <= '0;
      hdr_hi    <= '0;
      pix_dtype <= '0;
      hidx      <= '0;
    end else begin
      dvo_q <= 1'b0;
      if (is_pix) pix_dtype <= s.dtypei;
      if (hit) begin
        // The sample's last bit always lies in the most recently loaded pixel word.
        dvo_q   <= 1'b1;
        dtype_q <= is_pix ? s.dtypei : pix_dtype;
        if (itype_q == '0) begin
          meta_q <= raw_meta;
          r_q    <= '0;
          g_q    <= '0;
          b_q    <= '0;
        end else begin
          meta_q <= '0;
          r_q    <= sample[PIXEL_WIDTH-1:0];
          g_q    <= sample[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
          b_q    <= sample[3*PIXEL_WIDTH-1:2*PIXEL_WIDTH];
        end
      end else if (state == HDR_HI) begin
        dvo_q   <= 1'b1;
        dtype_q <= `DTYPE_HEADER;
        meta_q  <= hdr_hi;
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
        state   <= RUN;
      end else if (is_hdr) begin
        dvo_q   <= 1'b1;
        dtype_q <= `DTYPE_HEADER;
        meta_q  <= s.datai[15:0];
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
        hdr_hi  <= s.datai[31:16];
        state   <= HDR_HI;
      end else if (is_start || is_other) begin
        dvo_q   <= 1'b1;
        dtype_q <= s.dtypei;
        meta_q  <= '0;
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
      end

      if (is_start) begin
        hidx <= '0;
      end else if (hdr_emit) begin
        hidx <= hidx + 1'b1;
        if (hidx == HIDX_WIDTH'(`Image_image_type)) itype_q <= hdr_val;
      end
    end
  end

  assign s.dvo         = dvo_q;
  assign s.dtypeo      = dtype_q;
  assign s.meta_datao  = meta_q;
  assign s.r           = r_q;
  assign s.g           = g_q;
  assign s.b           = b_q;
  assign s.image_typeo = itype_q;
endmodule

// File: tb/tb_stream2rgb.sv
// tb/tb_stream2rgb.sv - self-checking bench for stream2rgb
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 16
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 16'hFF00
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 16'h0001
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 16'h0002
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 16'h0004
`endif
`ifndef Image_image_type
`define Image_image_type 2
`endif

module tb_stream2rgb;
  localparam int PW = 10;
  localparam int SH = 0;
  localparam logic [15:0] T_FS   = `DTYPE_FRAME_START;
  localparam logic [15:0] T_HS   = `DTYPE_HEADER_START;
  localparam logic [15:0] T_HDR  = `DTYPE_HEADER;
  localparam logic [15:0] T_PIX  = 16'h0100;
  localparam logic [15:0] T_PIX2 = 16'h0200;
  localparam logic [15:0] T_OTH  = 16'h0010;

  typedef struct packed {
    logic [15:0]   dt;
    logic [15:0]   meta;
    logic [PW-1:0] r;
    logic [PW-1:0] g;
    logic [PW-1:0] b;
  } out_t;

  typedef struct packed {
    logic [15:0]    dt;
    logic [31:0]    d;
    logic [1:0]     n;
    logic           rdy;
    out_t [2:0]     e;
  } vec_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int checks = 0;
  int errors = 0;
  out_t expq[$];
  bit   mq[$];
  logic [15:0] m_it;
  int   m_hidx;
  vec_t tbl[12];

  stream2rgb_if #(.PIXEL_WIDTH(PW)) bus ();
  stream2rgb #(.PIXEL_WIDTH(PW), .RAW_PIXEL_SHIFT(SH)) dut (.clk(clk), .resetb(resetb), .s(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(input logic [15:0] dt, input logic [15:0] m,
                              input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
    out_t o;
    o.dt = dt; o.meta = m; o.r = r; o.g = g; o.b = b;
    return o;
  endfunction

  function automatic vec_t vec(input logic [15:0] dt, input logic [31:0] d, input logic [1:0] n,
                               input logic rdy, input out_t o0, input out_t o1, input out_t o2);
    vec_t v;
    v.dt = dt; v.d = d; v.n = n; v.rdy = rdy;
    v.e[0] = o0; v.e[1] = o1; v.e[2] = o2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (resetb && bus.dvo) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got dtype=%h meta=%h r=%h g=%h b=%h want none",
                   bus.dtypeo, bus.meta_datao, bus.r, bus.g, bus.b);
        end else begin
          out_t e;
          e = expq.pop_front();
          chk("output", 64'(mk(bus.dtypeo, bus.meta_datao, bus.r, bus.g, bus.b)), 64'(e));
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input logic [15:0] dt, input logic [31:0] d, input bit rnd);
    int  t;
    bit  done;
    t = 0;
    done = 1'b0;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.dtypei = dt;
    bus.datai  = d;
    while (!done && t < 100) begin
      bus.dvi = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      done = bus.dvi && bus.rdyo;
      @(negedge clk);
      t++;
    end
    bus.dvi = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=no_accept want=accept dtype=%h data=%h", dt, d);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_it = '0;
    m_hidx = 0;
  endtask

  task automatic model_hdr(input logic [15:0] v);
    expq.push_back(mk(T_HDR, v, '0, '0, '0));
    if (m_hidx == `Image_image_type) m_it = v;
    m_hidx++;
  endtask

  // Reference: words become a plain bit queue, samples are popped P bits at a time.
  task automatic model_word(input logic [15:0] dt, input logic [31:0] d);
    if ((dt & `DTYPE_PIXEL_MASK) != '0) begin
      int p;
      p = (m_it == '0) ? PW : 3 * PW;
      for (int i = 0; i < 32; i++) mq.push_back(d[i]);
      while (mq.size() >= p) begin
        logic [3*PW-1:0]    sm;
        logic [3*PW+SH+15:0] wide;
        sm = '0;
        for (int k = 0; k < p; k++) sm[k] = mq.pop_front();
        if (m_it == '0) begin
          wide = '0;
          wide[3*PW-1:0] = sm;
          wide = wide << SH;
          expq.push_back(mk(dt, wide[15:0], '0, '0, '0));
        end else begin
          expq.push_back(mk(dt, 16'h0, sm[PW-1:0], sm[2*PW-1:PW], sm[3*PW-1:2*PW]));
        end
      end
    end else if (dt == T_FS || dt == T_HS) begin
      mq.delete();
      m_hidx = 0;
      expq.push_back(mk(dt, 16'h0, '0, '0, '0));
    end else if (dt == T_HDR) begin
      model_hdr(d[15:0]);
      model_hdr(d[31:16]);
    end else begin
      expq.push_back(mk(dt, 16'h0, '0, '0, '0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dvo"}, 64'(bus.dvo), 64'(0));
    chk({tag, "_dtypeo"}, 64'(bus.dtypeo), 64'(0));
    chk({tag, "_meta"}, 64'(bus.meta_datao), 64'(0));
    chk({tag, "_rgb"}, 64'({bus.r, bus.g, bus.b}), 64'(0));
    chk({tag, "_image_type"}, 64'(bus.image_typeo), 64'(0));
    chk({tag, "_rdyo"}, 64'(bus.rdyo), 64'(1));
  endtask

  initial begin
    out_t z;
    int t;
    z = '0;
    bus.dvi = 1'b0;
    bus.dtypei = '0;
    bus.datai = '0;

    tbl[0]  = vec(T_FS,   32'h0,        2'd1, 1'b1, mk(T_FS, 16'h0, 0, 0, 0), z, z);
    tbl[1]  = vec(T_PIX,  32'hC0300801, 2'd3, 1'b0, mk(T_PIX, 16'h001, 0, 0, 0),
                  mk(T_PIX, 16'h002, 0, 0, 0), mk(T_PIX, 16'h003, 0, 0, 0));
    tbl[2]  = vec(T_PIX,  32'h000000FF, 2'd3, 1'b0, mk(T_PIX, 16'h3FF, 0, 0, 0),
                  mk(T_PIX, 16'h000, 0, 0, 0), mk(T_PIX, 16'h000, 0, 0, 0));
    tbl[3]  = vec(T_FS,   32'h0,        2'd1, 1'b1, mk(T_FS, 16'h0, 0, 0, 0), z, z);
    tbl[4]  = vec(T_PIX,  32'h00000005, 2'd3, 1'b0, mk(T_PIX, 16'h005, 0, 0, 0),
                  mk(T_PIX, 16'h000, 0, 0, 0), mk(T_PIX, 16'h000, 0, 0, 0));
    tbl[5]  = vec(T_HS,   32'h0,        2'd1, 1'b1, mk(T_HS, 16'h0, 0, 0, 0), z, z);
    tbl[6]  = vec(T_HDR,  32'h00020001, 2'd2, 1'b0, mk(T_HDR, 16'h0001, 0, 0, 0),
                  mk(T_HDR, 16'h0002, 0, 0, 0), z);
    tbl[7]  = vec(T_HDR,  32'h00000001, 2'd2, 1'b0, mk(T_HDR, 16'h0001, 0, 0, 0),
                  mk(T_HDR, 16'h0000, 0, 0, 0), z);
    tbl[8]  = vec(T_OTH,  32'h00001234, 2'd1, 1'b1, mk(T_OTH, 16'h0, 0, 0, 0), z, z);
    tbl[9]  = vec(T_PIX,  32'h3FFAA955, 2'd1, 1'b1, mk(T_PIX, 16'h0, 10'h155, 10'h2AA, 10'h3FF), z, z);
    tbl[10] = vec(T_PIX,  32'hFFFFFFFF, 2'd1, 1'b1, mk(T_PIX, 16'h0, 10'h3FC, 10'h3FF, 10'h3FF), z, z);
    tbl[11] = vec(T_PIX2, 32'h00000000, 2'd1, 1'b1, mk(T_PIX2, 16'h0, 10'h00F, 10'h000, 10'h000), z, z);

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) expq.push_back(tbl[i].e[k]);
      send(tbl[i].dt, tbl[i].d, 1'b0);
      chk($sformatf("row%0d_latency_dvo", i), 64'(bus.dvo), 64'(1));
      chk($sformatf("row%0d_rdyo", i), 64'(bus.rdyo), 64'(tbl[i].rdy));
      if (i == 1) begin
        @(negedge clk);
        chk("raw_rdyo_low_2nd", 64'(bus.rdyo), 64'(0));
        @(negedge clk);
        chk("raw_rdyo_back_high", 64'(bus.rdyo), 64'(1));
      end
      if (i == 7) chk("image_type_from_header", 64'(bus.image_typeo), 64'(1));
    end

    // Reset in the middle of an rgb frame with residual bits held.
    expq.push_back(mk(T_PIX, 16'h0, 0, 0, 0));
    send(T_PIX, 32'h0, 1'b0);
    chk("pre_reset_dvo", 64'(bus.dvo), 64'(1));
    #2;
    resetb = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    expq.delete();
    model_reset();
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    model_word(T_PIX, 32'h00000005);
    send(T_PIX, 32'h00000005, 1'b0);
    chk("post_reset_first_sample", 64'(bus.meta_datao), 64'(16'h0005));

    // Randomised 64x4 rgb frame with dvi toggling.
    model_word(T_FS, 32'h0);             send(T_FS, 32'h0, 1'b1);
    model_word(T_HS, 32'h0);             send(T_HS, 32'h0, 1'b1);
    model_word(T_HDR, 32'h0000_0000);    send(T_HDR, 32'h0000_0000, 1'b1);
    model_word(T_HDR, 32'h0000_0001);    send(T_HDR, 32'h0000_0001, 1'b1);
    for (int w = 0; w < 240; w++) begin
      logic [31:0] d;
      logic [15:0] dt;
      d  = $urandom;
      dt = ($urandom_range(0, 1) == 0) ? T_PIX : T_PIX2;
      if ($urandom_range(0, 15) == 0) begin
        model_word(T_OTH, 32'h0);
        send(T_OTH, 32'h0, 1'b1);
      end
      model_word(dt, d);
      send(dt, d, 1'b1);
    end
    t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("random_frame_drained", 64'(expq.size()), 64'(0));
    chk("random_frame_image_type", 64'(bus.image_typeo), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
